aska_sched: RTL and testbench

ASKA_SCHED -- requirements
Module: aska_sched

---
 rtl/aska_pkg.sv | 17 +
 rtl/aska_rr_arb.sv | 24 ++
 rtl/aska_sched.sv | 134 +++++++++++++
 tb/tb_aska_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aska_pkg.sv
// Shared constants and types for the aska stimulation pulse scheduler.
package aska_pkg;
    localparam int NCH_DEF        = 4;
    localparam int GUARD_CYC_DEF  = 2;
    localparam int START_TO_DEF   = 4;
    localparam int MIN_PERIOD_DEF = 2;
    localparam int CW             = 12;  // per-channel period/counter width
    localparam int TMR_W          = 8;   // FSM timer, covers START_TO and GUARD_CYC

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GUARD
    } state_t;
endpackage

// File: rtl/aska_rr_arb.sv
// Combinational round-robin picker: first pending channel after ptr, wrapping.
module aska_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  winner,
    output logic           any
);
    always_comb begin
        logic [IW-1:0] idx;
        winner = '0;
        any    = 1'b0;
        idx    = ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = (idx == IW'(NCH - 1)) ? '0 : idx + IW'(1);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/aska_sched.sv
// Time-shares one aska pulse generator among NCH periodic stimulation channels.
// GUARD_CYC and START_TO must be at least 1.
module aska_sched
    import aska_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int GUARD_CYC  = GUARD_CYC_DEF,
    parameter int START_TO   = START_TO_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    localparam int IW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH-1:0]    ch_en,
    input  logic [CW*NCH-1:0] ch_period,
    input  logic              pulse_active,
    input  logic [NCH-1:0]    missed_clr,
    output logic [IW-1:0]     grant_idx,
    output logic              grant_valid,
    output logic              pulse_start,
    output logic [NCH-1:0]    missed,
    output logic              fault
);
    state_t             state, state_n;
    logic [TMR_W-1:0]   tmr, tmr_n;
    logic [IW-1:0]      ptr, ptr_n, idx_n, winner;
    logic               fault_n, any, take;
    logic [NCH-1:0]     pending;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] per, cnt;
        logic          act, expire, clr, pend, miss;

        assign per    = ch_period[CW*i +: CW];
        assign act    = enable && ch_en[i] && (per >= CW'(MIN_PERIOD));
        // >= rather than == so a period shrunk below the live count still wraps
        assign expire = act && (cnt >= per - CW'(1));
        assign clr    = take && (winner == IW'(i));

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt  <= '0;
                pend <= 1'b0;
                miss <= 1'b0;
            end else begin
                if (!act) begin
                    cnt  <= '0;
                    pend <= 1'b0;
                end else begin
                    cnt  <= expire ? '0 : cnt + CW'(1);
                    pend <= expire | (pend & ~clr);
                end
                // an expiry landing on the grant edge refills pending, not a miss
                miss <= (expire & pend & ~clr) | (miss & ~missed_clr[i]);
            end
        end

        assign pending[i] = pend;
        assign missed[i]  = miss;
    end

    aska_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req    (pending),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        fault_n = fault;
        idx_n   = grant_idx;
        ptr_n   = ptr;
        take    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && any && !fault) begin
                    take    = 1'b1;
                    idx_n   = winner;
                    ptr_n   = winner;
                    state_n = S_START;
                end
            end
            S_START: begin
                tmr_n   = '0;
                state_n = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (pulse_active) begin
                    state_n = S_WAIT_LO;
                end else if (tmr == TMR_W'(START_TO - 1)) begin
                    fault_n = 1'b1;
                    tmr_n   = '0;
                    state_n = S_GUARD;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!pulse_active) begin
                    tmr_n   = '0;
                    state_n = S_GUARD;
                end
            end
            S_GUARD: begin
                if (tmr == TMR_W'(GUARD_CYC - 1)) state_n = S_IDLE;
                else                               tmr_n   = tmr + TMR_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tmr         <= '0;
            fault       <= 1'b0;
            grant_idx   <= '0;
            ptr         <= IW'(NCH - 1);
            pulse_start <= 1'b0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            fault       <= fault_n;
            grant_idx   <= idx_n;
            ptr         <= ptr_n;
            pulse_start <= (state_n == S_START);
            grant_valid <= (state_n != S_IDLE);
        end
    end
endmodule

// File: tb/tb_aska_sched.sv
// Directed bench for aska_sched with a behavioural pulse-generator responder.
module tb_aska_sched;
    logic        clk, reset, enable, pulse_active;
    logic [3:0]  ch_en, missed_clr, missed;
    logic [47:0] ch_period;
    logic [1:0]  grant_idx;
    logic        grant_valid, pulse_start, fault;

    int total = 0;
    int bad   = 0;
    bit gen_on = 0;
    int gen_hold = 1;

    aska_sched dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_en        (ch_en),
        .ch_period    (ch_period),
        .pulse_active (pulse_active),
        .missed_clr   (missed_clr),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .pulse_start  (pulse_start),
        .missed       (missed),
        .fault        (fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Generator: sees pulse_start, then holds pulse_active for gen_hold cycles.
    initial begin
        pulse_active = 0;
        forever begin
            @(negedge clk);
            if (gen_on && pulse_start) begin
                pulse_active = 1;
                repeat (gen_hold) @(negedge clk);
                pulse_active = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1; enable = 0; ch_en = 0; ch_period = 0; missed_clr = 0; gen_on = 0;
        repeat (60) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; ch_en = 4'b0001; ch_period = 48'd2; missed_clr = 0; gen_on = 0;
        repeat (6) @(negedge clk);
        total++; if (pulse_start !== 1'b0) begin bad++; $display("FAIL rst_pulse_start got=%b exp=0", pulse_start); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_grant_valid got=%b exp=0", grant_valid); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL rst_grant_idx got=%0d exp=0", grant_idx); end
        total++; if (missed !== 4'b0000) begin bad++; $display("FAIL rst_missed got=%b exp=0000", missed); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
    endtask

    task automatic test_single();
        int p0 = -1, p1 = -1, fall = -1, n = 0;
        do_reset();
        gen_on = 1; gen_hold = 3;
        enable = 1; ch_en = 4'b0001; ch_period = {12'd0, 12'd0, 12'd0, 12'd400};
        for (int t = 1; t <= 805; t++) begin
            @(negedge clk);
            if (pulse_start) begin
                if (n == 0) p0 = t;
                else if (n == 1) p1 = t;
                n++;
                total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL single_idx t=%0d got=%0d exp=0", t, grant_idx); end
            end
            if (p0 > 0 && fall < 0 && !grant_valid) fall = t;
        end
        total++; if (p0 != 401) begin bad++; $display("FAIL single_first got=%0d exp=401", p0); end
        total++; if (p1 != 801) begin bad++; $display("FAIL single_second got=%0d exp=801", p1); end
        total++; if (fall != 407) begin bad++; $display("FAIL single_guard_end got=%0d exp=407", fall); end
        total++; if (n != 2) begin bad++; $display("FAIL single_count got=%0d exp=2", n); end
    endtask

    task automatic test_round_robin();
        int pt[8];
        int pi[8];
        int n = 0;
        int exp_t[8] = '{101, 115, 129, 143, 201, 215, 229, 243};
        do_reset();
        for (int k = 0; k < 8; k++) begin pt[k] = -1; pi[k] = -1; end
        gen_on = 1; gen_hold = 10;
        enable = 1; ch_en = 4'b1111; ch_period = {12'd100, 12'd100, 12'd100, 12'd100};
        for (int t = 1; t <= 250; t++) begin
            @(negedge clk);
            if (pulse_start && n < 8) begin pt[n] = t; pi[n] = int'(grant_idx); n++; end
        end
        for (int k = 0; k < 8; k++) begin
            total++; if (pi[k] != k % 4) begin bad++; $display("FAIL rr_idx%0d got=%0d exp=%0d", k, pi[k], k % 4); end
            total++; if (pt[k] != exp_t[k]) begin bad++; $display("FAIL rr_time%0d got=%0d exp=%0d", k, pt[k], exp_t[k]); end
        end
        total++; if (missed !== 4'b0000) begin bad++; $display("FAIL rr_missed got=%b exp=0000", missed); end
    endtask

    task automatic test_missed();
        do_reset();
        gen_on = 1; gen_hold = 30;
        enable = 1; ch_en = 4'b0010; ch_period = {12'd0, 12'd0, 12'd20, 12'd0};
        for (int t = 1; t <= 121; t++) begin
            @(negedge clk);
            case (t)
                79: begin
                    total++; if (missed !== 4'b0000) begin bad++; $display("FAIL miss_before got=%b exp=0000", missed); end
                end
                80: begin
                    total++; if (missed !== 4'b0010) begin bad++; $display("FAIL miss_set got=%b exp=0010", missed); end
                    missed_clr = 4'b0010;
                end
                81: begin
                    missed_clr = 4'b0000;
                    total++; if (missed !== 4'b0000) begin bad++; $display("FAIL miss_clear got=%b exp=0000", missed); end
                end
                119: missed_clr = 4'b0010;
                120: begin
                    missed_clr = 4'b0000;
                    total++; if (missed !== 4'b0010) begin bad++; $display("FAIL miss_set_wins got=%b exp=0010", missed); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_fault();
        int late = 0;
        do_reset();
        gen_on = 0;
        enable = 1; ch_en = 4'b0001; ch_period = {12'd0, 12'd0, 12'd0, 12'd10};
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t > 11 && pulse_start) late++;
            case (t)
                11: begin total++; if (pulse_start !== 1'b1) begin bad++; $display("FAIL flt_start got=%b exp=1", pulse_start); end end
                15: begin total++; if (fault !== 1'b0) begin bad++; $display("FAIL flt_early got=%b exp=0", fault); end end
                16: begin total++; if (fault !== 1'b1) begin bad++; $display("FAIL flt_set got=%b exp=1", fault); end end
                17: begin total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL flt_guard got=%b exp=1", grant_valid); end end
                18: begin total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL flt_idle got=%b exp=0", grant_valid); end end
                40: begin total++; if (missed !== 4'b0001) begin bad++; $display("FAIL flt_missed got=%b exp=0001", missed); end end
                default: ;
            endcase
        end
        total++; if (late != 0) begin bad++; $display("FAIL flt_no_grant got=%0d exp=0", late); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL flt_sticky got=%b exp=1", fault); end
    endtask

    task automatic test_enable_drop();
        int quiet = 0, again = -1;
        do_reset();
        gen_on = 1; gen_hold = 10;
        enable = 1; ch_en = 4'b0001; ch_period = {12'd0, 12'd0, 12'd0, 12'd10};
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t > 11 && t <= 40 && pulse_start) quiet++;
            if (t > 40 && again < 0 && pulse_start) again = t;
            case (t)
                11: begin total++; if (pulse_start !== 1'b1) begin bad++; $display("FAIL en_start got=%b exp=1", pulse_start); end end
                16: enable = 0;
                23: begin total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL en_guard got=%b exp=1", grant_valid); end end
                24: begin total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL en_idle got=%b exp=0", grant_valid); end end
                40: enable = 1;
                default: ;
            endcase
        end
        total++; if (quiet != 0) begin bad++; $display("FAIL en_quiet got=%0d exp=0", quiet); end
        total++; if (again != 51) begin bad++; $display("FAIL en_restart got=%0d exp=51", again); end
    endtask

    task automatic test_short_period_reset();
        int ch2_grants = 0;
        do_reset();
        gen_on = 1; gen_hold = 50;
        enable = 1; ch_en = 4'b0110; ch_period = {12'd0, 12'd1, 12'd10, 12'd0};
        for (int t = 1; t <= 70; t++) begin
            @(negedge clk);
            if (pulse_start && grant_idx == 2'd2) ch2_grants++;
            case (t)
                11: begin total++; if (grant_idx !== 2'd1) begin bad++; $display("FAIL sp_idx got=%0d exp=1", grant_idx); end end
                20: reset = 1;
                21: begin
                    reset = 0;
                    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL sp_rst_gv got=%b exp=0", grant_valid); end
                    total++; if (pulse_start !== 1'b0) begin bad++; $display("FAIL sp_rst_ps got=%b exp=0", pulse_start); end
                    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL sp_rst_idx got=%0d exp=0", grant_idx); end
                    total++; if (fault !== 1'b0) begin bad++; $display("FAIL sp_rst_fault got=%b exp=0", fault); end
                end
                32: begin
                    total++; if (pulse_start !== 1'b1) begin bad++; $display("FAIL sp_regrant got=%b exp=1", pulse_start); end
                    total++; if (grant_idx !== 2'd1) begin bad++; $display("FAIL sp_regrant_idx got=%0d exp=1", grant_idx); end
                end
                default: ;
            endcase
        end
        total++; if (ch2_grants != 0) begin bad++; $display("FAIL sp_ch2 got=%0d exp=0", ch2_grants); end
    endtask

    initial begin
        reset = 1; enable = 0; ch_en = 0; ch_period = 0; missed_clr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_missed();
        test_fault();
        test_enable_drop();
        test_short_period_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
